muldiv_unit: RTL and testbench

//   Parametrised iterative multiply/divide unit for the multicycle datapath; replaces the

---
 rtl/muldiv_if.sv | 27 ++
 rtl/muldiv_unit.sv | 179 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// muldiv_if: start/done handshake and result bus shared by the multiply/divide
// unit (slave side) and whoever issues operations to it (master side).
interface muldiv_if #(
   parameter int WIDTH = 32
) ();

   logic             Start;
   logic [1:0]       Op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Busy;
   logic             Done;
   logic             DivZero;
   logic [WIDTH-1:0] ResultHigh;
   logic [WIDTH-1:0] ResultLow;

   modport master (
      output Start, Op, A, B,
      input  Busy, Done, DivZero, ResultHigh, ResultLow
   );

   modport slave (
      input  Start, Op, A, B,
      output Busy, Done, DivZero, ResultHigh, ResultLow
   );

endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed/unsigned multiply and divide behind one
// start/done handshake. Both operations work on operand magnitudes, one bit
// per cycle, and a single FIX cycle restores the signs afterwards.
// Op encoding: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU (bit 0 = unsigned, bit 1 = divide).
module muldiv_unit #(
   parameter  int WIDTH = 32,
   localparam int CNTW  = $clog2(WIDTH + 1)
) (
   input  logic     Clk,
   input  logic     Reset,
   muldiv_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE,
      MUL,
      DIV,
      FIX,
      DONE
   } state_t;

   state_t             state_q;
   logic               isDiv_q;
   logic               signA_q;
   logic               signB_q;
   logic               dz_q;
   logic [CNTW-1:0]    cnt_q;
   logic [WIDTH-1:0]   operand_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic [WIDTH-1:0]   hi_d;
   logic [WIDTH-1:0]   lo_d;
   logic               busy_q;
   logic               done_q;
   logic               divZero_q;
   logic [WIDTH-1:0]   resHi_q;
   logic [WIDTH-1:0]   resLo_q;

   logic               inSignA;
   logic               inSignB;
   logic [WIDTH-1:0]   magA;
   logic [WIDTH-1:0]   magB;
   logic [WIDTH:0]     mulSum;
   logic [WIDTH:0]     divShift;
   logic [WIDTH:0]     divDiff;
   logic               divTake;
   logic [2*WIDTH-1:0] prodNeg;

   // Operand signs and magnitudes of the incoming request; only signed ops
   // (Op[0]==0) treat the MSB as a sign bit. -2^(W-1) maps to 2^(W-1) unsigned.
   always_comb begin
      inSignA = ~bus.Op[0] & bus.A[WIDTH-1];
      inSignB = ~bus.Op[0] & bus.B[WIDTH-1];
      magA    = inSignA ? (~bus.A + 1'b1) : bus.A;
      magB    = inSignB ? (~bus.B + 1'b1) : bus.B;
   end

   // One iteration of the shift-add multiplier, the restoring divider, or the
   // sign fix-up, selected by the current state. hi/lo hold the running
   // product (MUL) or remainder/quotient (DIV); operand_q is the multiplicand
   // or divisor magnitude.
   always_comb begin
      hi_d     = hi_q;
      lo_d     = lo_q;
      mulSum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, operand_q} : '0);
      divShift = {hi_q, lo_q[WIDTH-1]};
      divDiff  = divShift - {1'b0, operand_q};
      divTake  = ~divDiff[WIDTH];
      prodNeg  = ~{hi_q, lo_q} + 1'b1;
      case (state_q)
         MUL: begin
            hi_d = mulSum[WIDTH:1];
            lo_d = {mulSum[0], lo_q[WIDTH-1:1]};
         end
         DIV: begin
            hi_d = divTake ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], divTake};
         end
         FIX: begin
            if (isDiv_q) begin
               hi_d = signA_q ? (~hi_q + 1'b1) : hi_q;
               lo_d = (signA_q ^ signB_q) ? (~lo_q + 1'b1) : lo_q;
            end else if (signA_q ^ signB_q) begin
               hi_d = prodNeg[2*WIDTH-1:WIDTH];
               lo_d = prodNeg[WIDTH-1:0];
            end
         end
         default: begin
            hi_d = hi_q;
            lo_d = lo_q;
         end
      endcase
   end

   // Control FSM with registered handshake and result outputs. Done is raised
   // on the edge leaving DONE, so it appears one cycle after the state does;
   // Busy stays high through that Done cycle and drops on the following edge.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q   <= IDLE;
         isDiv_q   <= 1'b0;
         signA_q   <= 1'b0;
         signB_q   <= 1'b0;
         dz_q      <= 1'b0;
         cnt_q     <= '0;
         operand_q <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         divZero_q <= 1'b0;
         resHi_q   <= '0;
         resLo_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (done_q) begin
                  done_q <= 1'b0;
                  busy_q <= 1'b0;
               end else if (bus.Start && !busy_q) begin
                  busy_q    <= 1'b1;
                  divZero_q <= 1'b0;
                  isDiv_q   <= bus.Op[1];
                  signA_q   <= inSignA;
                  signB_q   <= inSignB;
                  cnt_q     <= '0;
                  dz_q      <= 1'b0;
                  if (!bus.Op[1]) begin
                     hi_q      <= '0;
                     lo_q      <= magB;
                     operand_q <= magA;
                     state_q   <= MUL;
                  end else if (bus.B == '0) begin
                     hi_q    <= bus.A;
                     lo_q    <= '1;
                     dz_q    <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     hi_q      <= '0;
                     lo_q      <= magA;
                     operand_q <= magB;
                     state_q   <= DIV;
                  end
               end
            end
            MUL, DIV: begin
               hi_q  <= hi_d;
               lo_q  <= lo_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNTW'(WIDTH - 1)) begin
                  state_q <= FIX;
               end
            end
            FIX: begin
               hi_q    <= hi_d;
               lo_q    <= lo_d;
               state_q <= DONE;
            end
            DONE: begin
               resHi_q   <= hi_q;
               resLo_q   <= lo_q;
               divZero_q <= dz_q;
               done_q    <= 1'b1;
               state_q   <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.Busy       = busy_q;
   assign bus.Done       = done_q;
   assign bus.DivZero    = divZero_q;
   assign bus.ResultHigh = resHi_q;
   assign bus.ResultLow  = resLo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: drives a 32-bit and an 8-bit muldiv_unit with directed
// operations and compares every cycle against an arithmetic reference model.
module tb_muldiv_unit;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   logic Clk = 1'b0;
   logic Reset;

   muldiv_if #(.WIDTH(32)) bus32 ();
   muldiv_if #(.WIDTH(8))  bus8 ();

   muldiv_unit #(.WIDTH(32)) dut32 (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus32)
   );

   muldiv_unit #(.WIDTH(8)) dut8 (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus8)
   );

   int vectors     = 0;
   int miscompares = 0;
   int edgeCount   = 0;

   // Expected state per unit: index 0 is the 32-bit unit, index 1 the 8-bit unit.
   logic        expValid [2];
   logic [31:0] expHi    [2];
   logic [31:0] expLo    [2];
   logic        expDz    [2];
   int          expEdge  [2];
   logic [31:0] lastHi   [2];
   logic [31:0] lastLo   [2];
   logic        lastDz   [2];

   // Free-running clock and edge counter used for latency checks.
   always #5 Clk = ~Clk;

   always @(posedge Clk) edgeCount++;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Reference model from plain integer arithmetic: returns {DivZero, High, Low}.
   function automatic logic [64:0] modelOp(input int w, input logic [1:0] op,
                                            input logic [31:0] aIn, input logic [31:0] bIn);
      logic [31:0] mask;
      logic [31:0] a;
      logic [31:0] b;
      longint      sa;
      longint      sb;
      logic [63:0] p;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      a  = aIn & mask;
      b  = bIn & mask;
      sa = (!op[0] && a[w-1]) ? (longint'(a) - (longint'(1) << w)) : longint'(a);
      sb = (!op[0] && b[w-1]) ? (longint'(b) - (longint'(1) << w)) : longint'(b);
      dz = 1'b0;
      if (!op[1]) begin
         if (op[0]) p = 64'(a) * 64'(b);
         else       p = 64'(sa * sb);
         hi = 32'(p >> w) & mask;
         lo = 32'(p) & mask;
      end else if (b == 32'd0) begin
         dz = 1'b1;
         hi = a;
         lo = mask;
      end else if (op[0]) begin
         hi = a % b;
         lo = a / b;
      end else begin
         hi = 32'(sa % sb) & mask;
         lo = 32'(sa / sb) & mask;
      end
      return {dz, hi, lo};
   endfunction

   // Per-cycle comparison of one unit against the expectation arrays.
   task automatic compareUnit(input int sel, input logic busy, input logic done, input logic dz,
                              input logic [31:0] hi, input logic [31:0] lo);
      string u;
      u = (sel == 0) ? "u32" : "u8";
      if (!Reset) begin
         checkOutput({u, "_rst_busy"}, 32'(busy), 32'd0);
         checkOutput({u, "_rst_done"}, 32'(done), 32'd0);
         checkOutput({u, "_rst_dz"}, 32'(dz), 32'd0);
         checkOutput({u, "_rst_hi"}, hi, 32'd0);
         checkOutput({u, "_rst_lo"}, lo, 32'd0);
      end else begin
         checkOutput({u, "_busy"}, 32'(busy), 32'(expValid[sel]));
         if (done) begin
            checkOutput({u, "_done_expected"}, 32'(expValid[sel]), 32'd1);
            checkOutput({u, "_done_edge"}, 32'(edgeCount), 32'(expEdge[sel]));
            checkOutput({u, "_hi"}, hi, expHi[sel]);
            checkOutput({u, "_lo"}, lo, expLo[sel]);
            checkOutput({u, "_divzero"}, 32'(dz), 32'(expDz[sel]));
            lastHi[sel]   = expHi[sel];
            lastLo[sel]   = expLo[sel];
            lastDz[sel]   = expDz[sel];
            expValid[sel] = 1'b0;
         end else begin
            checkOutput({u, "_hold_hi"}, hi, lastHi[sel]);
            checkOutput({u, "_hold_lo"}, lo, lastLo[sel]);
            checkOutput({u, "_hold_dz"}, 32'(dz), 32'(lastDz[sel]));
         end
      end
   endtask

   // Sample both units on the falling edge, away from the active edge.
   always @(negedge Clk) begin
      compareUnit(0, bus32.Busy, bus32.Done, bus32.DivZero, bus32.ResultHigh, bus32.ResultLow);
      compareUnit(1, bus8.Busy, bus8.Done, bus8.DivZero,
                  {24'd0, bus8.ResultHigh}, {24'd0, bus8.ResultLow});
   end

   // Issue one operation and record what the model says it must produce;
   // operands are scrambled right after acceptance to show they are not reused.
   task automatic applyStimulus(input int sel, input logic [1:0] op,
                                input logic [31:0] a, input logic [31:0] b);
      logic [64:0] r;
      int          w;
      w = (sel == 0) ? 32 : 8;
      @(negedge Clk);
      if (sel == 0) begin
         bus32.Start = 1'b1; bus32.Op = op; bus32.A = a; bus32.B = b;
      end else begin
         bus8.Start = 1'b1; bus8.Op = op; bus8.A = a[7:0]; bus8.B = b[7:0];
      end
      @(posedge Clk);
      #1;
      r = modelOp(w, op, a, b);
      expValid[sel] = 1'b1;
      expDz[sel]    = r[64];
      expHi[sel]    = r[63:32];
      expLo[sel]    = r[31:0];
      expEdge[sel]  = edgeCount + (r[64] ? 1 : w + 2);
      lastDz[sel]   = 1'b0;
      if (sel == 0) begin
         bus32.Start = 1'b0; bus32.Op = ~op; bus32.A = $urandom; bus32.B = $urandom;
      end else begin
         bus8.Start = 1'b0; bus8.Op = ~op; bus8.A = 8'($urandom); bus8.B = 8'($urandom);
      end
   endtask

   // Bounded wait for the compare process to retire the pending result.
   task automatic waitDone(input int sel);
      for (int i = 0; i < 100; i++) begin
         @(posedge Clk);
         if (!expValid[sel]) break;
      end
      checkOutput("done_timeout", 32'(expValid[sel]), 32'd0);
      expValid[sel] = 1'b0;
   endtask

   task automatic runOp(input int sel, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      applyStimulus(sel, op, a, b);
      waitDone(sel);
   endtask

   task automatic pinModel(input string name, input int w, input logic [1:0] op,
                           input logic [31:0] a, input logic [31:0] b, input logic [64:0] expected);
      logic [64:0] r;
      r = modelOp(w, op, a, b);
      checkOutput({name, "_hi"}, r[63:32], expected[63:32]);
      checkOutput({name, "_lo"}, r[31:0], expected[31:0]);
      checkOutput({name, "_dz"}, 32'(r[64]), 32'(expected[64]));
   endtask

   // Main sequence: reset, model pins, directed vectors on both widths, then
   // the ignored-Start / mid-operation reset scenario.
   initial begin
      int e0;
      for (int i = 0; i < 2; i++) begin
         expValid[i] = 1'b0; expHi[i] = '0; expLo[i] = '0; expDz[i] = 1'b0; expEdge[i] = 0;
         lastHi[i] = '0; lastLo[i] = '0; lastDz[i] = 1'b0;
      end
      bus32.Start = 1'b0; bus32.Op = 2'b00; bus32.A = '0; bus32.B = '0;
      bus8.Start  = 1'b0; bus8.Op  = 2'b00; bus8.A  = '0; bus8.B  = '0;
      Reset = 1'b1;
      #1 Reset = 1'b0;
      repeat (3) @(negedge Clk);
      Reset = 1'b1;

      pinModel("pin_mult",   32, OP_MULT,  32'hFFFF_FFFD, 32'd7,         {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
      pinModel("pin_multu",  32, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {1'b0, 32'hFFFF_FFFE, 32'h0000_0001});
      pinModel("pin_div",    32, OP_DIV,   32'hFFFF_FFF9, 32'd2,         {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
      pinModel("pin_divu",   32, OP_DIVU,  32'd7,         32'd2,         {1'b0, 32'd1,         32'd3});
      pinModel("pin_div0",   32, OP_DIV,   32'd5,         32'd0,         {1'b1, 32'd5,         32'hFFFF_FFFF});
      pinModel("pin_div8",    8, OP_DIV,   32'h80,        32'hFF,        {1'b0, 32'h00,        32'h80});
      pinModel("pin_multu8",  8, OP_MULTU, 32'hFF,        32'hFF,        {1'b0, 32'hFE,        32'h01});

      runOp(0, OP_MULT,  32'hFFFF_FFFD, 32'd7);
      runOp(0, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      runOp(0, OP_DIV,   32'hFFFF_FFF9, 32'd2);
      runOp(0, OP_DIVU,  32'd7,         32'd2);
      runOp(0, OP_DIV,   32'd5,         32'd0);
      runOp(0, OP_MULT,  32'd3,         32'd4);
      runOp(0, OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
      runOp(0, OP_DIV,   32'd7,         32'hFFFF_FFFE);
      runOp(0, OP_MULT,  32'h8000_0000, 32'h8000_0000);
      runOp(0, OP_DIVU,  32'hFFFF_FFFF, 32'h10);
      runOp(0, OP_DIVU,  32'd0,         32'd0);

      runOp(1, OP_MULT,  32'hFD, 32'd7);
      runOp(1, OP_MULTU, 32'hFF, 32'hFF);
      runOp(1, OP_DIV,   32'hF9, 32'd2);
      runOp(1, OP_DIVU,  32'd7,  32'd2);
      runOp(1, OP_DIV,   32'd5,  32'd0);
      runOp(1, OP_MULTU, 32'd2,  32'd3);
      runOp(1, OP_DIV,   32'h80, 32'hFF);
      runOp(1, OP_DIVU,  32'hFE, 32'd3);

      applyStimulus(0, OP_MULT, 32'd3, 32'd4);
      e0 = edgeCount;
      while (edgeCount < e0 + 9) @(posedge Clk);
      #1;
      bus32.Start = 1'b1; bus32.Op = OP_MULT; bus32.A = 32'd9; bus32.B = 32'd9;
      @(posedge Clk);
      #1 bus32.Start = 1'b0;
      while (edgeCount < e0 + 20) @(posedge Clk);
      #1;
      Reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         expValid[i] = 1'b0; lastHi[i] = '0; lastLo[i] = '0; lastDz[i] = 1'b0;
      end
      repeat (3) @(negedge Clk);
      Reset = 1'b1;
      repeat (40) @(posedge Clk);
      runOp(0, OP_MULT, 32'd3, 32'd4);

      repeat (2) @(negedge Clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
